// File: rtl/dm_pipe_if.sv
// dm_pipe_if: request/response channel of the pipelined data memory
interface dm_pipe_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_ssel;
  logic [2:0]  req_rsel;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pcadd8;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_exc;
  logic [4:0]  resp_exc_code;
  modport master (
    output req_valid, req_we, req_ssel, req_rsel, req_addr, req_wdata, req_pcadd8, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_exc, resp_exc_code
  );
  modport slave (
    input  req_valid, req_we, req_ssel, req_rsel, req_addr, req_wdata, req_pcadd8, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_exc, resp_exc_code
  );
endinterface

// File: rtl/dm_pipe.sv
// dm_pipe: pipelined data memory with in-order responses and exception reporting.
// Defining DM_WRITE_LOG_EN adds a per-store trace line.
module dm_pipe #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          READ_LAT   = 2
) (
  input logic       clk,
  input logic       reset,
  dm_pipe_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // 33-bit bounds so the top of the window never wraps
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);
  logic [31:0]           mem_q [DEPTH];
  logic                  advance, accept, wr_en;
  logic                  is_word, is_half, sel_bad, mis, oor, exc;
  logic [4:0]            code;
  logic [31:0]           off, word, shifted, ld_data, wmask, wrep, merged;
  logic [ADDR_WIDTH-1:0] idx;
  logic [READ_LAT-1:0]   v_q, v_d, e_q, e_d;
  logic [31:0]           d_q [READ_LAT];
  logic [31:0]           d_d [READ_LAT];
  logic [4:0]            c_q [READ_LAT];
  logic [4:0]            c_d [READ_LAT];
  logic                  unused_off;
  assign advance       = !v_q[READ_LAT-1] | bus.resp_ready;
  assign bus.req_ready = advance & !reset;
  assign accept        = bus.req_valid & bus.req_ready;
  assign unused_off    = ^off;
  always_comb begin
    is_word = bus.req_we ? bus.req_ssel == 2'd0 : bus.req_rsel == 3'd0;
    is_half = bus.req_we ? bus.req_ssel == 2'd1 : bus.req_rsel inside {3'd1, 3'd2};
    sel_bad = bus.req_we ? bus.req_ssel == 2'd3 : bus.req_rsel > 3'd4;
    mis     = is_word ? |bus.req_addr[1:0] : is_half & bus.req_addr[0];
    oor     = {1'b0, bus.req_addr} < {1'b0, BASE_ADDR} || {1'b0, bus.req_addr} >= LIMIT;
    exc     = sel_bad | mis | oor;
    code    = sel_bad ? 5'd10 : exc ? (bus.req_we ? 5'd5 : 5'd4) : 5'd0;
    off     = bus.req_addr - BASE_ADDR;
    idx     = off[ADDR_WIDTH+1:2];
    word    = mem_q[idx];
    shifted = word >> {bus.req_addr[1:0], 3'b000};
    ld_data = is_word ? word :
              is_half ? (bus.req_rsel == 3'd2 ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]}) :
              (bus.req_rsel == 3'd4 ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]});
    wmask   = is_word ? 32'hffff_ffff :
              is_half ? (bus.req_addr[1] ? 32'hffff_0000 : 32'h0000_ffff) :
              32'h0000_00ff << {bus.req_addr[1:0], 3'b000};
    wrep    = is_word ? bus.req_wdata : is_half ? {2{bus.req_wdata[15:0]}} : {4{bus.req_wdata[7:0]}};
    merged  = (word & ~wmask) | (wrep & wmask);
    wr_en   = accept & bus.req_we & !exc;
  end
  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else if (wr_en) mem_q[idx] <= merged;
  // stage 0 captures the accepted op; later stages shift toward the output
  for (genvar s = 0; s < READ_LAT; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign v_d[s] = accept;
      assign e_d[s] = accept & exc;
      assign d_d[s] = (accept & !bus.req_we & !exc) ? ld_data : 32'h0;
      assign c_d[s] = accept ? code : 5'd0;
    end else begin : g_tail
      assign v_d[s] = v_q[s-1];
      assign e_d[s] = e_q[s-1];
      assign d_d[s] = d_q[s-1];
      assign c_d[s] = c_q[s-1];
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      v_q <= '0;
      e_q <= '0;
      d_q <= '{default: '0};
      c_q <= '{default: '0};
    end else if (advance) begin
      v_q <= v_d;
      e_q <= e_d;
      d_q <= d_d;
      c_q <= c_d;
    end
  assign bus.resp_valid    = v_q[READ_LAT-1];
  assign bus.resp_exc      = e_q[READ_LAT-1];
  assign bus.resp_rdata    = d_q[READ_LAT-1];
  assign bus.resp_exc_code = c_q[READ_LAT-1];
`ifdef DM_WRITE_LOG_EN
  always_ff @(posedge clk)
    if (wr_en) $display("%d@%h: *%h <= %h", $time, bus.req_pcadd8 - 32'd8, {bus.req_addr[31:2], 2'b00}, merged);
`else
  logic unused_pc;
  assign unused_pc = ^bus.req_pcadd8;
`endif
endmodule

// File: tb/tb_dm_pipe.sv
// tb_dm_pipe: directed bench for dm_pipe checked against a byte-level memory model
module tb_dm_pipe;
  localparam int          AW    = 10;
  localparam int          DEPTH = 2 ** AW;
  localparam int          RL    = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  typedef struct {
    logic [31:0] rdata;
    logic        exc;
    logic [4:0]  code;
    int          cyc;
  } exp_t;
  logic        clk = 0;
  logic        reset = 1;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          n_pop = 0;
  int          last_lat = 0;
  logic [31:0] last_rdata = 0;
  logic        last_exc = 0;
  logic [4:0]  last_code = 0;
  logic        rr_low = 0;
  logic [7:0]  mb [4*DEPTH];
  exp_t        q[$];
  dm_pipe_if bus();
  dm_pipe #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .READ_LAT(RL)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask
  task automatic model_clear();
    for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'h0;
  endtask
  // expected response from access size, alignment and window rules applied to a byte array
  task automatic predict(input logic we, input logic [1:0] ss, input logic [2:0] rs,
                         input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    int n;
    longint off;
    logic [31:0] v;
    e.rdata = 0;
    e.exc = 0;
    e.code = 0;
    e.cyc = 0;
    n = we ? (ss == 0 ? 4 : ss == 1 ? 2 : 1) : (rs == 0 ? 4 : rs < 3 ? 2 : 1);
    off = longint'(a) - longint'(BASE);
    if (we ? ss == 3 : rs > 4) begin
      e.exc = 1;
      e.code = 10;
    end else if (a % n != 0 || off < 0 || off >= 4*DEPTH) begin
      e.exc = 1;
      e.code = we ? 5 : 4;
    end else if (we) begin
      for (int b = 0; b < n; b++) mb[off+b] = wd[8*b +: 8];
    end else begin
      v = 0;
      for (int b = 0; b < n; b++) v[8*b +: 8] = mb[off+b];
      if (n < 4 && (rs == 2 || rs == 4) && v[8*n-1]) for (int b = n; b < 4; b++) v[8*b +: 8] = 8'hff;
      e.rdata = v;
    end
  endtask
  task automatic op(input logic we, input logic [1:0] ss, input logic [2:0] rs,
                    input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    bit done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      bus.req_valid = 1;
      bus.req_we = we;
      bus.req_ssel = ss;
      bus.req_rsel = rs;
      bus.req_addr = a;
      bus.req_wdata = wd;
      bus.req_pcadd8 = 32'h0000_3008;
      #1;
      if (bus.req_ready) begin
        predict(we, ss, rs, a, wd, e);
        e.cyc = cyc;
        q.push_back(e);
        done = 1;
      end
      @(posedge clk);
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout addr=%h got=no_accept want=accept", a);
    end
  endtask
  task automatic drain();
    int k = 0;
    @(negedge clk);
    bus.req_valid = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout got=%0d pending want=0", q.size());
    end
  endtask
  task automatic ld_lit(input string name, input logic [2:0] rs, input logic [31:0] a, input logic [31:0] want);
    op(0, 0, rs, a, 0);
    drain();
    chk(name, last_rdata, want);
  endtask
  task automatic exc_lit(input string name, input logic we, input logic [1:0] ss, input logic [2:0] rs,
                         input logic [31:0] a, input logic [4:0] want);
    op(we, ss, rs, a, 32'hffff_ffff);
    drain();
    chk({name, "_code"}, 32'(last_code), 32'(want));
    chk({name, "_exc"}, 32'(last_exc), 32'd1);
    chk({name, "_rdata"}, last_rdata, 32'h0);
  endtask
  // compare process: every cycle a response is visible it must match the queue head
  always begin : cmp
    exp_t e;
    @(negedge clk);
    #2;
    if (!reset && bus.resp_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp got=%h want=none", bus.resp_rdata);
      end else begin
        e = q[0];
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_exc", 32'(bus.resp_exc), 32'(e.exc));
        chk("resp_code", 32'(bus.resp_exc_code), 32'(e.code));
        if (bus.resp_ready) begin
          void'(q.pop_front());
          n_pop++;
          last_rdata = bus.resp_rdata;
          last_exc = bus.resp_exc;
          last_code = bus.resp_exc_code;
          last_lat = cyc - e.cyc;
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end
  initial begin
    int base_pop;
    bus.req_valid = 0;
    bus.req_we = 0;
    bus.req_ssel = 0;
    bus.req_rsel = 0;
    bus.req_addr = 0;
    bus.req_wdata = 0;
    bus.req_pcadd8 = 0;
    bus.resp_ready = 1;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 0;
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_resp_exc", 32'(bus.resp_exc), 32'd0);
    chk("rst_resp_code", 32'(bus.resp_exc_code), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    op(1, 0, 0, 32'h0, 32'h8765_4321);
    op(0, 0, 0, 32'h0, 0);
    drain();
    chk("lw0", last_rdata, 32'h8765_4321);
    chk("lw0_latency", 32'(last_lat), 32'(RL));
    op(1, 1, 0, 32'h4, 32'h1234_8765);
    op(1, 1, 0, 32'h6, 32'h1234_8765);
    ld_lit("lw4", 0, 32'h4, 32'h8765_8765);
    op(1, 2, 0, 32'h8, 32'h87);
    op(1, 2, 0, 32'h9, 32'h78);
    op(1, 2, 0, 32'ha, 32'h87);
    op(1, 2, 0, 32'hb, 32'h56);
    ld_lit("lw8", 0, 32'h8, 32'h5687_7887);
    ld_lit("lhu4", 1, 32'h4, 32'h0000_8765);
    ld_lit("lh4", 2, 32'h4, 32'hffff_8765);
    ld_lit("lbu5", 3, 32'h5, 32'h0000_0087);
    ld_lit("lb7", 4, 32'h7, 32'hffff_ff87);
    ld_lit("lb4", 4, 32'h4, 32'h0000_0065);
    op(1, 2, 0, 32'hc, 32'h11);
    op(1, 2, 0, 32'hd, 32'h22);
    ld_lit("sb_b2b", 0, 32'hc, 32'h0000_2211);
    exc_lit("lw_mis", 0, 0, 0, 32'h2, 5'd4);
    exc_lit("sh_mis", 1, 1, 0, 32'h1, 5'd5);
    ld_lit("after_sh_mis", 0, 32'h0, 32'h8765_4321);
    exc_lit("lw_oor", 0, 0, 0, 32'(4*DEPTH), 5'd4);
    exc_lit("rsel_bad", 0, 0, 3'b101, 32'h0, 5'd10);
    exc_lit("ssel_bad", 1, 3, 0, 32'h0, 5'd10);
    ld_lit("after_ssel_bad", 0, 32'h0, 32'h8765_4321);
    exc_lit("sw_oor_hi", 1, 0, 0, 32'hffff_fffc, 5'd5);
    base_pop = n_pop;
    fork
      begin
        for (int i = 0; i < 6; i++) op(0, 0, 0, 32'(4*i), 0);
      end
      begin
        repeat (2) @(negedge clk);
        bus.resp_ready = 0;
        repeat (3) begin
          #1;
          if (!bus.req_ready) rr_low = 1;
          @(negedge clk);
        end
        bus.resp_ready = 1;
      end
    join
    drain();
    chk("bp_req_ready_dropped", 32'(rr_low), 32'd1);
    chk("bp_resp_count", 32'(n_pop - base_pop), 32'd6);
    chk("bp_last", last_rdata, 32'h0);
    op(0, 0, 0, 32'h0, 0);
    op(0, 0, 0, 32'h4, 0);
    @(negedge clk);
    reset = 1;
    q.delete();
    model_clear();
    bus.req_valid = 1;
    bus.req_we = 0;
    bus.req_rsel = 0;
    bus.req_addr = 32'h0;
    @(negedge clk);
    reset = 0;
    bus.req_valid = 0;
    #1;
    chk("rst_flush_valid", 32'(bus.resp_valid), 32'd0);
    ld_lit("rst_cleared", 0, 32'h0, 32'h0);
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
